// File: rtl/exec_interval_monitor.sv
// -----------------------------------------------------------------------------
// exec_interval_monitor
//
// Purpose:
//   Timestamps start/stop strobes from the monitored core against the
//   free-running execution-cycle count. It computes the elapsed cycles for
//   each execution and can optionally flag intervals that fall outside
//   [in_min, in_max]. Each {anomaly, interval} record goes into a small
//   circular FIFO, which is drained through a valid/ready read port.
//
// Configuration:
//   EXEC_MON_BOUNDS_EN - when defined, the bound comparators are built and
//                        the anomaly flag is computed. When undefined,
//                        in_min/in_max are ignored and out_anomaly is
//                        always 0.
//
// Parameters:
//   WIDTH - width of the cycle count and of the interval (default 32)
//   DEPTH - FIFO entries, a power of two that is at least 2 (default 8)
//
// Ports:
//   in_clk        clock
//   in_reset      synchronous, active-high reset
//   in_cycle      current execution cycle count
//   in_start      single-cycle pulse marking the start of an execution
//   in_stop       single-cycle pulse marking the end of an execution
//   in_min        lower bound on the interval, inclusive
//   in_max        upper bound on the interval, inclusive
//   in_ready      reader accepts the head record
//   out_valid     FIFO not empty
//   out_interval  interval of the head record
//   out_anomaly   bounds-violation flag of the head record
//   out_busy      a measurement is in progress (RUNNING)
//   out_overflow  sticky; set when a record was dropped on a full FIFO
//   out_count     FIFO occupancy
// -----------------------------------------------------------------------------
module exec_interval_monitor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic [WIDTH-1:0]         in_cycle,
  input  logic                     in_start,
  input  logic                     in_stop,
  input  logic [WIDTH-1:0]         in_min,
  input  logic [WIDTH-1:0]         in_max,
  input  logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_interval,
  output logic                     out_anomaly,
  output logic                     out_busy,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUNNING
  } state_e;

  // Measurement FSM state
  state_e           state_q, state_d;
  logic [WIDTH-1:0] stamp_q, stamp_d;

  // FIFO bookkeeping. DEPTH is a power of two, so the pointers wrap on
  // their own.
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   mem [DEPTH];      // {anomaly, interval}

  logic [WIDTH-1:0] interval;
  logic             anomaly;
  logic             rec_push;
  logic             fifo_full;
  logic             fifo_pop;
  logic             push_ok;
  logic [WIDTH:0]   head;

  // Modular subtraction, so a wrap of the cycle counter between start and
  // stop still gives the true elapsed count.
  assign interval = in_cycle - stamp_q;

`ifdef EXEC_MON_BOUNDS_EN
  assign anomaly = (interval < in_min) || (interval > in_max);
`else
  // The bounds are unused in this build. Reducing them here keeps them
  // visibly consumed.
  logic unused_bounds;
  assign unused_bounds = ^{in_min, in_max};
  assign anomaly       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. If a
    // path is left unassigned, a latch is inferred.
    state_d  = state_q;
    stamp_d  = stamp_q;
    rec_push = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A stop with no measurement open is ignored.
        if (in_start) begin
          stamp_d = in_cycle;
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (in_stop) begin
          // The record uses the old stamp. A coincident start opens the
          // next measurement straight away.
          rec_push = 1'b1;
          if (in_start) begin
            stamp_d = in_cycle;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (in_start) begin
          stamp_d = in_cycle;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  assign fifo_full = (count_q == CW'(DEPTH));
  assign fifo_pop  = (count_q != '0) && in_ready;
  // When the FIFO is full, a push still succeeds if a pop frees the slot in
  // the same cycle.
  assign push_ok   = rec_push && (!fifo_full || fifo_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (rec_push && fifo_full && !fifo_pop);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge inputs regardless of statement order.
    if (in_reset) begin
      state_q    <= ST_IDLE;
      stamp_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stamp_q    <= stamp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset. Its contents only become
  // observable through a valid pointer/count pair, and the outputs are
  // gated below, so stale data never escapes after a reset.
  always_ff @(posedge in_clk) begin
    if (!in_reset && push_ok) begin
      mem[wr_ptr_q] <= {anomaly, interval};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head         = mem[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_interval = out_valid ? head[WIDTH-1:0] : '0;
  assign out_anomaly  = out_valid && head[WIDTH];
  assign out_busy     = (state_q == ST_RUNNING);
  assign out_overflow = overflow_q;
  assign out_count    = count_q;

endmodule

// File: tb/tb_exec_interval_monitor.sv
// -----------------------------------------------------------------------------
// tb_exec_interval_monitor
//
// Directed bench for exec_interval_monitor (WIDTH=32, DEPTH=8). Inputs are
// driven 1 ns after the rising edge. Outputs are sampled 1 ns after the
// following edge. Anomaly expectations follow EXEC_MON_BOUNDS_EN.
// -----------------------------------------------------------------------------
module tb_exec_interval_monitor;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

`ifdef EXEC_MON_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] cycle = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] min_b = 32'd10;
  logic [WIDTH-1:0] max_b = 32'd300;
  logic             ready = 1'b0;
  logic             valid;
  logic [WIDTH-1:0] interval;
  logic             anomaly;
  logic             busy;
  logic             overflow;
  logic [3:0]       count;

  int vectors    = 0;
  int miscompares = 0;

  exec_interval_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .in_clk       (clk),
    .in_reset     (rst),
    .in_cycle     (cycle),
    .in_start     (start),
    .in_stop      (stop),
    .in_min       (min_b),
    .in_max       (max_b),
    .in_ready     (ready),
    .out_valid    (valid),
    .out_interval (interval),
    .out_anomaly  (anomaly),
    .out_busy     (busy),
    .out_overflow (overflow),
    .out_count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected anomaly for the fixed bounds [10, 300].
  function automatic logic exp_anom(input logic [WIDTH-1:0] iv);
    return BOUNDS_EN && ((iv < 32'd10) || (iv > 32'd300));
  endfunction

  // One start/stop pair. On return, the record has just been pushed.
  task automatic measure(input logic [WIDTH-1:0] t0, input logic [WIDTH-1:0] t1);
    cycle = t0; start = 1'b1; tick();
    start = 1'b0; cycle = t1; stop = 1'b1; tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    vectors++;
    if ({valid, busy, overflow, anomaly} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {valid, busy, overflow, anomaly});
    end
    vectors++;
    if (interval !== '0 || count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: got interval=%0d count=%0d expected 0/0", interval, count);
    end
  endtask

  task automatic test_basic();
    ready = 1'b1;
    cycle = 32'd100; start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    cycle = 32'd350; stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (valid !== 1'b1 || interval !== 32'd250 || anomaly !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_record: got v=%b iv=%0d a=%b busy=%b expected 1/250/0/0",
               valid, interval, anomaly, busy);
    end
    tick();
    vectors++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      miscompares++; $display("FAIL basic_one_cycle: got v=%b count=%0d expected 0/0", valid, count);
    end
  endtask

  task automatic test_bounds();
    logic [WIDTH-1:0] ivs [3];
    ivs[0] = 32'd400; ivs[1] = 32'd10; ivs[2] = 32'd9;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      measure(32'd1000, 32'd1000 + ivs[i]);
      vectors++;
      if (valid !== 1'b1 || interval !== ivs[i] || anomaly !== exp_anom(ivs[i])) begin
        miscompares++;
        $display("FAIL bounds_%0d: got v=%b iv=%0d a=%b expected 1/%0d/%b",
                 i, valid, interval, anomaly, ivs[i], exp_anom(ivs[i]));
      end
    end
    tick();
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    measure(32'hFFFF_FFF0, 32'h0000_0010);
    vectors++;
    if (valid !== 1'b1 || interval !== 32'h20 || anomaly !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: got v=%b iv=%0h a=%b expected 1/20/0", valid, interval, anomaly);
    end
    tick();
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      measure(32'd5000, 32'd5000 + 32'(20 + 5 * i));
      if (i == 7) begin
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_full: got count=%0d ovf=%b expected 8/0", count, overflow);
        end
      end
    end
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b1 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop: got count=%0d ovf=%b v=%b expected 8/1/1", count, overflow, valid);
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (valid !== 1'b1 || interval !== 32'(20 + 5 * i)) begin
        miscompares++;
        $display("FAIL drain_%0d: got v=%b iv=%0d expected 1/%0d", i, valid, interval, 20 + 5 * i);
      end
      tick();
    end
    vectors++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      miscompares++; $display("FAIL drain_empty: got v=%b count=%0d expected 0/0", valid, count);
    end
    ready = 1'b0;
  endtask

  task automatic test_strobes();
    ready = 1'b0;
    // Stop while idle
    cycle = 32'd900; stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (count !== 4'd0 || busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_stop: got count=%0d busy=%b v=%b expected 0/0/0", count, busy, valid);
    end
    // Start, start, stop: measured from the second start
    cycle = 32'd1000; start = 1'b1; tick();
    cycle = 32'd1100; tick(); start = 1'b0;
    cycle = 32'd1150; stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (count !== 4'd1 || interval !== 32'd50 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart: got count=%0d iv=%0d busy=%b expected 1/50/0", count, interval, busy);
    end
    // Simultaneous start+stop while running
    cycle = 32'd2000; start = 1'b1; tick();
    cycle = 32'd2070; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    vectors++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      miscompares++; $display("FAIL both_strobes: got count=%0d busy=%b expected 2/1", count, busy);
    end
    cycle = 32'd2100; stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (count !== 4'd3 || busy !== 1'b0 || interval !== 32'd50) begin
      miscompares++;
      $display("FAIL three_queued: got count=%0d busy=%b head=%0d expected 3/0/50", count, busy, interval);
    end
    // Check the 70 and 30 records, then refill so the reset test sees three.
    ready = 1'b1; tick();
    vectors++;
    if (interval !== 32'd70) begin
      miscompares++; $display("FAIL both_old_stamp: got %0d expected 70", interval);
    end
    tick();
    vectors++;
    if (interval !== 32'd30) begin
      miscompares++; $display("FAIL both_new_stamp: got %0d expected 30", interval);
    end
    ready = 1'b0;
    measure(32'd10, 32'd20);
    measure(32'd10, 32'd30);
  endtask

  task automatic test_reset_running();
    cycle = 32'd7000; start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset: got count=%0d busy=%b expected 3/1", count, busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if (count !== 4'd0 || busy !== 1'b0 || overflow !== 1'b0 || valid !== 1'b0 || interval !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got count=%0d busy=%b ovf=%b v=%b iv=%0d expected all 0",
               count, busy, overflow, valid, interval);
    end
  endtask

  task automatic test_zero_interval();
    ready = 1'b1;
    cycle = 32'd500; start = 1'b1; tick();
    stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    vectors++;
    if (valid !== 1'b1 || interval !== 32'd0 || anomaly !== exp_anom(32'd0) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_iv: got v=%b iv=%0d a=%b busy=%b expected 1/0/%b/1",
               valid, interval, anomaly, busy, exp_anom(32'd0));
    end
    cycle = 32'd510; stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (valid !== 1'b1 || interval !== 32'd10 || anomaly !== 1'b0 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL after_zero: got v=%b iv=%0d a=%b count=%0d expected 1/10/0/1",
               valid, interval, anomaly, count);
    end
    tick();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++; $display("FAIL final_empty: got v=%b expected 0", valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_bounds();
    test_wrap();
    test_overflow();
    test_strobes();
    test_reset_running();
    test_zero_interval();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
